// File: rtl/mem_ctrl_mp_pkg.sv
// Shared definitions for the multi-page burst memory controller:
// FSM state type, page constants and the wrapping burst address helper.
package mcDefs;

    localparam int unsigned MEMPAGE0 = 1;
    localparam int unsigned MEMPAGE1 = 2;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RWAIT,
        READ,
        RDRAIN
    } mcState_t;

    // Critical-word-first: beat k stays inside the burst-aligned block of base.
    function automatic int unsigned wrapAddr(input int unsigned base,
                                             input int unsigned beat,
                                             input int unsigned burst_len);
        return (base & ~(burst_len - 1)) | ((base + beat) & (burst_len - 1));
    endfunction

endpackage

// File: rtl/mc_burst_addr.sv
// Beat counter and wrapping array-address generator for one burst.
// Writes present the address one cycle late to line up with the registered write data.
module mc_burst_addr
    import mcDefs::*;
#(
    parameter  int unsigned ADDR_W    = 16,
    parameter  int unsigned PAGE_BITS = 4,
    parameter  int unsigned BASE_PAGE = MEMPAGE1,
    parameter  int unsigned NUM_PAGES = 2,
    parameter  int unsigned BURST_LEN = 4,
    localparam int unsigned OFF_W     = ADDR_W - PAGE_BITS,
    localparam int unsigned PIDX_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
    localparam int unsigned MEM_AW    = PIDX_W + OFF_W
) (
    input  logic              clk,
    input  logic              resetH,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    input  logic              wr_mode,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              last
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);

    logic [PIDX_W-1:0] page_idx;
    logic [OFF_W-1:0]  base_off;
    logic [BEAT_W-1:0] beat;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] addr_now;

    // NOTE: sequential state uses <= so every register updates together at the edge.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            page_idx <= '0;
            base_off <= '0;
            beat     <= '0;
            addr_q   <= '0;
        end else if (start) begin
            page_idx <= PIDX_W'(start_addr[ADDR_W-1:OFF_W] - PAGE_BITS'(BASE_PAGE));
            base_off <= start_addr[OFF_W-1:0];
            beat     <= '0;
        end else if (advance) begin
            beat   <= beat + 1'b1;
            addr_q <= addr_now;
        end
    end

    always_comb begin
        addr_now = {page_idx, OFF_W'(wrapAddr(32'(base_off), 32'(beat), BURST_LEN))};
    end

    assign mem_addr = wr_mode ? addr_q : addr_now;
    assign last     = (beat == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mem_ctrl_mp.sv
// Multi-page burst memory controller: bus slave over NUM_PAGES pages with
// wrapping bursts, read wait states, read-valid strobe and sticky protocol error.
module mem_ctrl_mp
    import mcDefs::*;
#(
    parameter  int unsigned ADDR_W      = 16,
    parameter  int unsigned PAGE_BITS   = 4,
    parameter  int unsigned BASE_PAGE   = MEMPAGE1,
    parameter  int unsigned NUM_PAGES   = 2,
    parameter  int unsigned BURST_LEN   = 4,
    parameter  int unsigned WAIT_STATES = 0,
    localparam int unsigned MEM_AW      = ((NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1)
                                          + ADDR_W - PAGE_BITS
) (
    input  logic              clk,
    input  logic              resetH,
    input  logic              AddrValid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] AddrDataIn,
    output logic [ADDR_W-1:0] AddrDataOut,
    output logic              AddrDataOE,
    output logic              DataValid,
    output logic              ProtoErr,
    output logic [MEM_AW-1:0] memAddr,
    output logic [ADDR_W-1:0] memWData,
    output logic              memWE,
    output logic              memRE,
    input  logic [ADDR_W-1:0] memRData
);

    localparam int unsigned          PW      = PAGE_BITS + 1;
    localparam logic [PAGE_BITS:0]   PAGE_LO = PW'(BASE_PAGE);
    localparam logic [PAGE_BITS:0]   PAGE_HI = PW'(BASE_PAGE + NUM_PAGES);

    mcState_t          state, state_next;
    logic [3:0]        wait_cnt;
    logic              is_write_q;
    logic              proto_err_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_wdata_q;
    logic              data_valid_q;
    logic              mem_re;
    logic              start;
    logic              advance;
    logic              last;
    logic [PAGE_BITS:0] page_ext;
    logic              page_hit;

    assign page_ext = {1'b0, AddrDataIn[ADDR_W-1:ADDR_W-PAGE_BITS]};
    assign page_hit = (page_ext >= PAGE_LO) && (page_ext < PAGE_HI);

    mc_burst_addr #(
        .ADDR_W   (ADDR_W),
        .PAGE_BITS(PAGE_BITS),
        .BASE_PAGE(BASE_PAGE),
        .NUM_PAGES(NUM_PAGES),
        .BURST_LEN(BURST_LEN)
    ) u_burst_addr (
        .clk       (clk),
        .resetH    (resetH),
        .start     (start),
        .start_addr(AddrDataIn),
        .advance   (advance),
        .wr_mode   (is_write_q),
        .mem_addr  (memAddr),
        .last      (last)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        advance    = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                if (AddrValid && page_hit) begin
                    start = 1'b1;
                    if (!rw)                  state_next = WRITE;
                    else if (WAIT_STATES > 0) state_next = RWAIT;
                    else                      state_next = READ;
                end
            end
            WRITE: begin
                advance = 1'b1;
                if (last) state_next = IDLE;
            end
            RWAIT: begin
                if (wait_cnt == 4'(WAIT_STATES - 1)) state_next = READ;
            end
            READ: begin
                mem_re  = 1'b1;
                advance = 1'b1;
                if (last) state_next = RDRAIN;
            end
            RDRAIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write data and enable trail the bus by one cycle; read strobes trail memRE.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            is_write_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            wait_cnt     <= (state == RWAIT) ? wait_cnt + 4'd1 : 4'd0;
            proto_err_q  <= proto_err_q | (AddrValid && (state != IDLE));
            mem_we_q     <= (state == WRITE);
            data_valid_q <= mem_re;
            if (start)
                is_write_q <= !rw;
            if (state == WRITE)
                mem_wdata_q <= AddrDataIn;
        end
    end

    assign memRE       = mem_re;
    assign memWE       = mem_we_q;
    assign memWData    = mem_wdata_q;
    assign DataValid   = data_valid_q;
    assign AddrDataOE  = data_valid_q;
    assign AddrDataOut = data_valid_q ? memRData : '0;
    assign ProtoErr    = proto_err_q;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Two controllers (0 and 3 wait states) on one shared bus, checked every cycle
// against a transaction-level schedule model built from the bus timing rules.
module tb_mem_ctrl_mp;
    import mcDefs::*;

    localparam int BASE      = 2;
    localparam int BL        = 4;
    localparam int MEM_WORDS = 8192;
    localparam int NCYC      = 3000;
    localparam int NEVER     = 1 << 30;

    logic        clk = 1'b0;
    logic        resetH = 1'b1;
    logic        AddrValid = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] AddrDataIn = '0;

    logic [15:0] dout_w  [2];
    logic        oe_w    [2];
    logic        dv_w    [2];
    logic        pe_w    [2];
    logic [12:0] addr_w  [2];
    logic [15:0] wd_w    [2];
    logic        we_w    [2];
    logic        re_w    [2];
    logic [15:0] rdata_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_ctrl_mp #(
            .ADDR_W(16), .PAGE_BITS(4), .BASE_PAGE(BASE), .NUM_PAGES(2),
            .BURST_LEN(BL), .WAIT_STATES(g * 3)
        ) u_dut (
            .clk(clk), .resetH(resetH), .AddrValid(AddrValid), .rw(rw),
            .AddrDataIn(AddrDataIn), .AddrDataOut(dout_w[g]), .AddrDataOE(oe_w[g]),
            .DataValid(dv_w[g]), .ProtoErr(pe_w[g]), .memAddr(addr_w[g]),
            .memWData(wd_w[g]), .memWE(we_w[g]), .memRE(re_w[g]), .memRData(rdata_w[g])
        );
    end

    always #5 clk = ~clk;

    // Array behind each controller's memory port.
    logic [15:0] env_mem [2][MEM_WORDS];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (re_w[d]) rdata_w[d] <= env_mem[d][addr_w[d]];
            if (we_w[d]) env_mem[d][addr_w[d]] <= wd_w[d];
        end
    end

    // Reference model: expected per-cycle activity plus contents of each array.
    logic [15:0] model_mem [2][MEM_WORDS];
    bit          exp_we [2][NCYC];
    bit          exp_re [2][NCYC];
    bit          exp_dv [2][NCYC];
    int          exp_addr [2][NCYC];
    logic [15:0] exp_wd [2][NCYC];
    logic [15:0] exp_rd [2][NCYC];
    int          busy_until [2];
    int          perr_at [2];
    bit          wr_active [2];
    int          wr_c0 [2];
    logic [15:0] wr_base [2];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit rst_next = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int mem_index(input logic [15:0] a, input int k);
        int page = int'(a[15:12]);
        int off  = int'(a[11:0]);
        return (page - BASE) * 4096 + (off / BL) * BL + (off + k) % BL;
    endfunction

    function automatic bit in_range(input logic [15:0] a);
        return (int'(a[15:12]) >= BASE) && (int'(a[15:12]) < BASE + 2);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = cyc; c < NCYC; c++) begin
                exp_we[d][c] = 1'b0;
                exp_re[d][c] = 1'b0;
                exp_dv[d][c] = 1'b0;
            end
            busy_until[d] = 0;
            perr_at[d]    = NEVER;
            wr_active[d]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            int w = d * 3;
            if (wr_active[d] && cyc > wr_c0[d] && cyc <= wr_c0[d] + BL) begin
                int k   = cyc - wr_c0[d] - 1;
                int idx = mem_index(wr_base[d], k);
                exp_we[d][cyc+1]   = 1'b1;
                exp_addr[d][cyc+1] = idx;
                exp_wd[d][cyc+1]   = AddrDataIn;
                model_mem[d][idx]  = AddrDataIn;
                if (k == BL - 1) wr_active[d] = 1'b0;
            end
            if (AddrValid) begin
                if (cyc < busy_until[d]) begin
                    if (perr_at[d] > cyc) perr_at[d] = cyc;
                end else if (in_range(AddrDataIn)) begin
                    if (!rw) begin
                        wr_active[d]  = 1'b1;
                        wr_c0[d]      = cyc;
                        wr_base[d]    = AddrDataIn;
                        busy_until[d] = cyc + BL + 1;
                    end else begin
                        for (int k = 0; k < BL; k++) begin
                            int idx = mem_index(AddrDataIn, k);
                            exp_re[d][cyc+1+w+k]   = 1'b1;
                            exp_addr[d][cyc+1+w+k] = idx;
                            exp_dv[d][cyc+2+w+k]   = 1'b1;
                            exp_rd[d][cyc+2+w+k]   = model_mem[d][idx];
                        end
                        busy_until[d] = cyc + BL + 2 + w;
                    end
                end
            end
        end
    endfunction

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("we%0d", d),   32'(we_w[d]), 32'(exp_we[d][cyc]));
            check($sformatf("re%0d", d),   32'(re_w[d]), 32'(exp_re[d][cyc]));
            check($sformatf("dv%0d", d),   32'(dv_w[d]), 32'(exp_dv[d][cyc]));
            check($sformatf("oe%0d", d),   32'(oe_w[d]), 32'(exp_dv[d][cyc]));
            check($sformatf("perr%0d", d), 32'(pe_w[d]), 32'(perr_at[d] < cyc));
            if (exp_we[d][cyc] || exp_re[d][cyc])
                check($sformatf("addr%0d", d), 32'(addr_w[d]), 32'(exp_addr[d][cyc]));
            if (exp_we[d][cyc])
                check($sformatf("wdata%0d", d), 32'(wd_w[d]), 32'(exp_wd[d][cyc]));
            if (exp_dv[d][cyc])
                check($sformatf("rdata%0d", d), 32'(dout_w[d]), 32'(exp_rd[d][cyc]));
        end
    endtask

    task automatic tick(input logic av, input logic r, input logic [15:0] din);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NCYC - 20) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 20);
            $fatal(1);
        end
        resetH     = rst_next;
        AddrValid  = av;
        rw         = r;
        AddrDataIn = din;
        if (!resetH) model_step();
        @(negedge clk);
        compare();
    endtask

    // One bus transaction lasting gap cycles; poke>0 adds an illegal AddrValid.
    task automatic issue(input logic r, input logic [15:0] a, input logic [63:0] data,
                         input int gap, input int poke);
        for (int i = 0; i < gap; i++) begin
            logic        av;
            logic [15:0] din;
            av = (i == 0) || (poke != 0 && i == poke);
            if (i == 0)                din = a;
            else if (!r && i <= BL)    din = data[16*(i-1) +: 16];
            else                       din = 16'($urandom);
            tick(av, r, din);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'($urandom));
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_re%0d", tag, d),   32'(re_w[d]),   32'd0);
            check($sformatf("%s_we%0d", tag, d),   32'(we_w[d]),   32'd0);
            check($sformatf("%s_dv%0d", tag, d),   32'(dv_w[d]),   32'd0);
            check($sformatf("%s_oe%0d", tag, d),   32'(oe_w[d]),   32'd0);
            check($sformatf("%s_perr%0d", tag, d), 32'(pe_w[d]),   32'd0);
            check($sformatf("%s_dout%0d", tag, d), 32'(dout_w[d]), 32'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < MEM_WORDS; i++) begin
                env_mem[d][i]   = '0;
                model_mem[d][i] = '0;
            end
        model_reset();
        idle(3);
        check_quiet("reset");
        rst_next = 1'b0;
        idle(2);

        // Write then read in the base page, write followed at the earliest legal cycle.
        issue(1'b0, 16'h2004, 64'h4444_3333_2222_1111, BL + 1, 0);
        issue(1'b1, 16'h2004, 64'h0, BL + 5, 0);
        issue(1'b1, 16'h2006, 64'h0, BL + 5, 0);
        // Second page and out-of-range pages.
        issue(1'b0, 16'h3010, 64'hDEAD_BEEF_CAFE_F00D, BL + 1, 0);
        issue(1'b1, 16'h3012, 64'h0, BL + 5, 0);
        issue(1'b0, 16'h4000, 64'h1234_5678_9ABC_DEF0, BL + 1, 0);
        issue(1'b1, 16'h4000, 64'h0, 3, 0);
        issue(1'b0, 16'h1FF0, 64'h1234_5678_9ABC_DEF0, BL + 1, 0);

        for (int n = 0; n < 60; n++) begin
            logic        r;
            logic [3:0]  page;
            logic [15:0] a;
            int          gap;
            r    = 1'($urandom_range(0, 1));
            page = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'(BASE + $urandom_range(0, 1));
            a    = {page, 12'($urandom_range(0, 31))};
            if (!in_range(a)) gap = 2;
            else if (r)       gap = BL + 5 + $urandom_range(0, 2);
            else              gap = BL + 1 + $urandom_range(0, 2);
            issue(r, a, {$urandom, $urandom}, gap, 0);
        end

        // Read followed at BL+2: legal with no wait states, an error with three.
        issue(1'b1, 16'h2008, 64'h0, BL + 2, 0);
        issue(1'b0, 16'h2008, 64'h0BAD_0A0B_0C0D_0E0F, BL + 5, 0);
        // AddrValid in cycle 2 of a write: burst completes, error sticks.
        issue(1'b0, 16'h200C, 64'h5555_6666_7777_8888, BL + 1, 2);
        issue(1'b1, 16'h200C, 64'h0, BL + 8, 0);
        idle(3);

        // Reset in cycle 3 of a read.
        tick(1'b1, 1'b1, 16'h2004);
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 16'h0);
        resetH = 1'b1;
        model_reset();
        #1;
        check_quiet("midrst");
        rst_next = 1'b1;
        idle(1);
        rst_next = 1'b0;
        idle(6);
        issue(1'b1, 16'h2004, 64'h0, BL + 5, 0);
        issue(1'b1, 16'h3010, 64'h0, BL + 5, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_mp.md
# mem_ctrl_mp

Parametrised multi-page burst memory controller: a slave on the main multiplexed address/data bus that claims a contiguous range of NUM_PAGES pages, rather than one fixed page, and services fixed-length read/write bursts against a local memory array. It adds configurable read wait states, critical-word-first wrapping burst addressing, an explicit read-data-valid strobe and a sticky protocol-error flag. It sits between the main bus slave side and the memory array port. It replaces the single-page memory interface in top-level builds.

## Interface
- ADDR_W, 16, bus address/data width
- PAGE_BITS, 4, upper address bits forming the page number
- BASE_PAGE, MEMPAGE1 (mcDefs), first page claimed
- NUM_PAGES, 2, pages claimed: BASE_PAGE..BASE_PAGE+NUM_PAGES-1; must be ≥1 and must not pass 2**PAGE_BITS-1
- BURST_LEN, 4, beats per burst, power of 2, ≥2
- WAIT_STATES, 0, extra cycles before the first read request to the array (0..15)
- MEM_AW, derived: $clog2(NUM_PAGES)+ADDR_W-PAGE_BITS (at least 1 page-index bit)
- clk  in  1  bus clock
- resetH  in  1  asynchronous, active-high reset
- AddrValid  in  1  address phase strobe from master
- rw  in  1  1=read, 0=write; sampled with AddrValid
- AddrDataIn  in  ADDR_W  address (address phase) or write data (data phases)
- AddrDataOut  out  ADDR_W  read data toward bus
- AddrDataOE  out  1  controller drives the bus
- DataValid  out  1  read beat present on AddrDataOut
- ProtoErr  out  1  sticky: AddrValid seen while the controller was busy
- memAddr  out  MEM_AW  array word address
- memWData  out  ADDR_W  array write data
- memWE  out  1  array write enable
- memRE  out  1  array read enable
- memRData  in  ADDR_W  array read data, valid the cycle after memRE

## Operation
- States: IDLE, WRITE, RWAIT, READ, RDRAIN.
- IDLE: on AddrValid with the page in range, latch the address, rw and beat=0. A write goes to WRITE. A read goes to RWAIT if WAIT_STATES>0, else to READ. An out-of-range page is ignored and drives no outputs.
- Array address: {page−BASE_PAGE, offset}. The offset of beat k is (A & ~(BURST_LEN-1)) | ((A+k) & (BURST_LEN-1)). This wraps inside the aligned block and the page never changes.
- WRITE: each cycle, register AddrDataIn into memWData. In the next cycle assert memWE with memAddr for that beat. After BURST_LEN beats, go to IDLE.
- RWAIT: count WAIT_STATES cycles, then go to READ.
- READ: assert memRE for BURST_LEN consecutive cycles, incrementing beat, then go to RDRAIN.
- RDRAIN: one cycle for the last array return, then go to IDLE.
- Read return: AddrDataOut = memRData (combinational pass-through). AddrDataOE and DataValid are registered copies of memRE.
- AddrValid outside IDLE does not restart the burst, and sets ProtoErr. ProtoErr clears only on reset.
- Read-modify, byte enables and variable burst length are not supported.

## Timing
- Reset (async, any state): state=IDLE, beat=0. All outputs are 0, including ProtoErr, memWE and memRE. A burst interrupted by reset issues no further array accesses.
- Cycle 0 is the cycle in which AddrValid is sampled.
- Write: data is on the bus in cycles 1..BURST_LEN. memWE is high in cycles 2..BURST_LEN+1.
- Read: memRE is high in cycles 1+W..BURST_LEN+W, where W = WAIT_STATES. DataValid and AddrDataOE are high in cycles 2+W..BURST_LEN+1+W.
- Earliest next AddrValid accepted without error:
  - after a write: cycle BURST_LEN+1, overlapping the final memWE.
  - after a read: cycle BURST_LEN+2+W.
- AddrDataOE is never high in a cycle where AddrValid may legally be driven by the master.

## Structure
- The mcDefs package gains:
  - the state enum typedef mcState_t.
  - the page constants, with MEMPAGE1 reused as the default BASE_PAGE.
  - a function wrapAddr(base, beat, BURST_LEN) shared by RTL and bench model.
- One sub-module, mc_burst_addr: holds the beat counter and the wrap address generator, and outputs memAddr and a last-beat flag.
- The FSM and bus/array steering stay in mem_ctrl_mp.

## Test plan
- Write then read, start in the claimed page: write 4 beats 0x1111..0x4444 at 0x2004 (BASE_PAGE=2) -> memWE cycles 2–5 at offsets 4,5,6,7. Read at 0x2004 -> DataValid cycles 2–5 returning the same words in order.
- Wrap: read at 0x2006 -> memAddr offsets 6,7,4,5.
- Second page: NUM_PAGES=2, write at 0x3010 -> memAddr = {1'b1, 12'h010..013}. An access at 0x4000 -> no memWE/memRE, no OE.
- Wait states: WAIT_STATES=3, read -> memRE cycles 4–7, DataValid cycles 5–8, OE low in cycles 1–4.
- Protocol error: AddrValid in cycle 2 of a write -> burst completes unchanged, ProtoErr=1 and held until resetH.
- Reset mid-read: assert resetH in cycle 3 -> memRE, DataValid, OE drop immediately. No array access after release. A fresh read completes normally.
